// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller: run/step/halt sequencing of a pipeline with post-HALT drain and cycle counting
module pipeline_run_controller #(
  parameter int NB_DATA      = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  input  logic [1:0]         i_cmd,
  input  logic               i_halt_fetched,
  output logic               o_cmd_ready,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_cycle_count,
  output logic               o_step_done,
  output logic               o_program_end,
  output logic [2:0]         o_state
);
  localparam int NB_DRAIN = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_END   = 3'd4
  } state_t;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_HALT = 2'b11;
  generate
    if (DRAIN_CYCLES < 1) begin : g_bad_drain
      $error("pipeline_run_controller: DRAIN_CYCLES must be >= 1");
    end
  endgenerate
  state_t              r_state;
  state_t              w_next_state;
  logic [NB_DRAIN-1:0] r_drain;
  logic [NB_DRAIN-1:0] w_next_drain;
  logic [NB_DATA-1:0]  r_cycle_count;
  logic                r_step_done;
  logic                w_accept;
  // All status outputs decode registered state only; inputs never reach them combinationally.
  assign o_valid       = (r_state == ST_RUN) || (r_state == ST_STEP) || (r_state == ST_DRAIN);
  assign o_cmd_ready   = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign o_program_end = (r_state == ST_END);
  assign o_state       = r_state;
  assign o_cycle_count = r_cycle_count;
  assign o_step_done   = r_step_done;
  assign w_accept      = i_cmd_valid && o_cmd_ready;
  always_comb begin
    w_next_state = r_state;
    w_next_drain = r_drain;
    case (r_state)
      ST_IDLE:
        w_next_state = !w_accept ? ST_IDLE :
                       (i_cmd == CMD_RUN)  ? ST_RUN  :
                       (i_cmd == CMD_STEP) ? ST_STEP : ST_IDLE;
      ST_RUN: begin
        // A fetched HALT opcode outranks a simultaneous pause command.
        if (i_halt_fetched) begin
          w_next_state = ST_DRAIN;
          w_next_drain = NB_DRAIN'(DRAIN_CYCLES);
        end else if (w_accept && i_cmd == CMD_HALT) begin
          w_next_state = ST_IDLE;
        end
      end
      ST_STEP: begin
        w_next_state = i_halt_fetched ? ST_DRAIN : ST_IDLE;
        w_next_drain = i_halt_fetched ? NB_DRAIN'(DRAIN_CYCLES) : r_drain;
      end
      ST_DRAIN: begin
        w_next_drain = r_drain - 1'b1;
        w_next_state = (r_drain == NB_DRAIN'(1)) ? ST_END : ST_DRAIN;
      end
      ST_END:  w_next_state = ST_END;
      default: w_next_state = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_drain       <= '0;
      r_cycle_count <= '0;
      r_step_done   <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_drain       <= w_next_drain;
      r_cycle_count <= o_valid ? r_cycle_count + 1'b1 : r_cycle_count;
      r_step_done   <= (r_state == ST_STEP);
    end
  end
endmodule

// File: tb/tb_pipeline_run_controller.sv
// tb_pipeline_run_controller: directed and randomized checks against a behavioural model of the run controller
module tb_pipeline_run_controller;
  localparam int NB = 8;
  localparam int DR = 4;
  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_cmd_valid = 1'b0;
  logic [1:0]    i_cmd = 2'b00;
  logic          i_halt_fetched = 1'b0;
  logic          o_cmd_ready;
  logic          o_valid;
  logic [NB-1:0] o_cycle_count;
  logic          o_step_done;
  logic          o_program_end;
  logic [2:0]    o_state;
  int n_chk = 0;
  int n_fail = 0;
  int n_pulse = 0;
  int m_state = 0;
  int m_drain = 0;
  int unsigned m_count = 0;
  bit m_sd = 1'b0;

  pipeline_run_controller #(.NB_DATA(NB), .DRAIN_CYCLES(DR)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .i_halt_fetched(i_halt_fetched), .o_cmd_ready(o_cmd_ready), .o_valid(o_valid),
    .o_cycle_count(o_cycle_count), .o_step_done(o_step_done),
    .o_program_end(o_program_end), .o_state(o_state)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: IDLE=0 RUN=1 STEP=2 DRAIN=3 END=4; m_drain is valid cycles left before END.
  task automatic model_edge(input bit cv, input logic [1:0] c, input bit hf);
    bit acc;
    acc = cv && (m_state == 0 || m_state == 1);
    if (m_state >= 1 && m_state <= 3) m_count = (m_count + 1) % (1 << NB);
    m_sd = (m_state == 2);
    if (m_state == 0) begin
      if (acc && c == 2'b01) m_state = 1;
      else if (acc && c == 2'b10) m_state = 2;
    end else if (m_state == 1 || m_state == 2) begin
      if (hf) begin
        m_state = 3;
        m_drain = DR;
      end else if (m_state == 2 || (acc && c == 2'b11)) begin
        m_state = 0;
      end
    end else if (m_state == 3) begin
      m_drain--;
      if (m_drain == 0) m_state = 4;
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_drain = 0;
    m_count = 0;
    m_sd = 1'b0;
  endtask

  task automatic check_all();
    chk("state", o_state, m_state);
    chk("valid", o_valid, m_state >= 1 && m_state <= 3);
    chk("cmd_ready", o_cmd_ready, m_state <= 1);
    chk("program_end", o_program_end, m_state == 4);
    chk("step_done", o_step_done, m_sd);
    chk("cycle_count", o_cycle_count, m_count);
  endtask

  task automatic cyc(input bit cv, input logic [1:0] c, input bit hf);
    i_cmd_valid = cv;
    i_cmd = c;
    i_halt_fetched = hf;
    @(posedge i_clock);
    model_edge(cv, c, hf);
    #1;
    check_all();
    if (o_step_done) n_pulse++;
  endtask

  // Asserts reset mid-cycle, checks the effect before any edge, releases on the falling edge.
  task automatic do_reset();
    #2;
    i_reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_state", o_state, 0);
    chk("rst_count", o_cycle_count, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_cmd_ready, 1);
    @(negedge i_clock);
    i_reset = 1'b1;
  endtask

  initial begin
    #3;
    check_all();
    #9 i_reset = 1'b1;
    cyc(1, 2'b01, 0);
    cyc(0, 2'b00, 0);
    do_reset();
    n_pulse = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 2'b10, 0);
      cyc(0, 2'b00, 0);
      cyc(0, 2'b00, 0);
    end
    chk("step3_count", o_cycle_count, 3);
    chk("step3_pulses", n_pulse, 3);
    chk("step3_state", o_state, 0);
    do_reset();
    cyc(1, 2'b01, 0);
    for (int k = 0; k < 9; k++) cyc(0, 2'b00, 0);
    cyc(0, 2'b00, 1);
    chk("drain_entry", o_state, 3);
    for (int k = 0; k < DR; k++) cyc(0, 2'b00, k == 1);
    chk("end_state", o_state, 4);
    chk("end_flag", o_program_end, 1);
    chk("end_valid", o_valid, 0);
    chk("end_count", o_cycle_count, 14);
    cyc(1, 2'b01, 0);
    cyc(1, 2'b10, 1);
    chk("end_sticky", o_state, 4);
    chk("end_count_held", o_cycle_count, 14);
    do_reset();
    cyc(1, 2'b01, 0);
    for (int k = 0; k < 4; k++) cyc(k == 2, 2'b10, 0);
    cyc(1, 2'b11, 0);
    chk("pause_state", o_state, 0);
    chk("pause_count", o_cycle_count, 5);
    cyc(0, 2'b00, 0);
    cyc(1, 2'b01, 0);
    cyc(0, 2'b00, 0);
    cyc(0, 2'b00, 0);
    cyc(1, 2'b11, 0);
    chk("resume_count", o_cycle_count, 8);
    do_reset();
    cyc(1, 2'b01, 0);
    cyc(1, 2'b11, 1);
    chk("halt_prio", o_state, 3);
    cyc(0, 2'b00, 0);
    do_reset();
    cyc(1, 2'b10, 0);
    cyc(0, 2'b00, 0);
    chk("post_rst_step", o_cycle_count, 1);
    do_reset();
    cyc(1, 2'b01, 0);
    for (int k = 0; k < 260; k++) cyc(0, 2'b00, 0);
    chk("wrap_count", o_cycle_count, 4);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) do_reset();
      else cyc(1'($urandom_range(1)), 2'($urandom_range(3)), $urandom_range(39) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
